port_requester: RTL and testbench

Ingress-side initiator for the 4-port switch arbiter. One instance sits on each input port. It buffers incoming packet words and reads the one-hot destination mask from each packet's header word. It then holds a request plus destination mask toward the arbiter and forwards one word to the crossbar for every granted cycle, aligned with the arbiter's registered mux selects.

---
 rtl/packet_pkg.sv | 14 +
 rtl/port_requester_if.sv | 28 ++
 rtl/sync_fifo.sv | 55 +++++
 rtl/port_requester.sv | 152 +++++++++++++++
 tb/tb_port_requester.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/packet_pkg.sv
// Shared widths and FSM state type for the switch ingress requesters.
package packet_pkg;

    localparam int unsigned NUM_PORTS  = 4;
    localparam int unsigned ADDR_WIDTH = NUM_PORTS;
    localparam int unsigned DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StDrop
    } req_state_e;

endpackage

// File: rtl/port_requester_if.sv
// Ingress, arbiter and crossbar signals of one switch input port.
// master = the requester, slave = its environment.
interface port_requester_if;
    import packet_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_eop;
    logic                  port_req;
    logic [ADDR_WIDTH-1:0] port_dst;
    logic                  grant;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_eop;
    logic                  drop_pulse;

    modport master (
        input  in_valid, in_data, in_eop, grant,
        output in_ready, port_req, port_dst, out_valid, out_data, out_eop, drop_pulse
    );

    modport slave (
        output in_valid, in_data, in_eop, grant,
        input  in_ready, port_req, port_dst, out_valid, out_data, out_eop, drop_pulse
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers; head word is read combinationally.
module sync_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == CntW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PtrW'(do_push);
        rd_ptr_d = rd_ptr_q + PtrW'(do_pop);
        cnt_d    = cnt_q + CntW'(do_push) - CntW'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/port_requester.sv
// Ingress requester: buffers packets, requests the arbiter with the header's
// destination mask and forwards one word per grant. Option: REQ_TIMEOUT_EN.
module port_requester
    import packet_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned TIMEOUT = 64
) (
    input logic              clk,
    input logic              rst_n,
    port_requester_if.master bus
);

    localparam int unsigned FifoW = DATA_WIDTH + 1;

    logic                  push, pop, fifo_full, fifo_empty;
    logic [FifoW-1:0]      head;
    logic                  head_eop;
    logic [DATA_WIDTH-1:0] head_data;
    logic [ADDR_WIDTH-1:0] head_dst;
    logic                  req, timeout_hit;

    req_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] dst_q, dst_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_eop_q, out_eop_d;
    logic                  drop_pulse_q, drop_pulse_d;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FifoW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({bus.in_eop, bus.in_data}),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign {head_eop, head_data} = head;
    assign head_dst              = head_data[ADDR_WIDTH-1:0];
    assign push                  = bus.in_valid && !fifo_full;
    assign req                   = (state_q == StReq) && !fifo_empty;

    always_comb begin
        state_d      = state_q;
        dst_d        = dst_q;
        out_valid_d  = 1'b0;
        out_data_d   = out_data_q;
        out_eop_d    = 1'b0;
        drop_pulse_d = 1'b0;
        pop          = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    dst_d = head_dst;
                    if (head_dst != '0) begin
                        state_d = StReq;
                    end else begin
                        state_d      = StDrop;
                        drop_pulse_d = 1'b1;
                    end
                end
            end
            StReq: begin
                if (req && bus.grant) begin
                    pop         = 1'b1;
                    out_valid_d = 1'b1;
                    out_data_d  = head_data;
                    out_eop_d   = head_eop;
                    if (head_eop) begin
                        state_d = StIdle;
                    end
                end else if (timeout_hit) begin
                    state_d      = StDrop;
                    drop_pulse_d = 1'b1;
                end
            end
            StDrop: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (head_eop) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

`ifdef REQ_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

    logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;

    // Fires on the TIMEOUT-th consecutive ungranted request cycle.
    assign timeout_hit = req && !bus.grant && (tmo_cnt_q == TmoW'(TIMEOUT - 1));

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_d != StReq || bus.grant) begin
            tmo_cnt_d = '0;
        end else if (req) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign unused_timeout = ^TIMEOUT;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            dst_q        <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_eop_q    <= 1'b0;
            drop_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            dst_q        <= dst_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_eop_q    <= out_eop_d;
            drop_pulse_q <= drop_pulse_d;
        end
    end

    assign bus.in_ready   = !fifo_full;
    assign bus.port_req   = req;
    assign bus.port_dst   = dst_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_eop    = out_eop_q;
    assign bus.drop_pulse = drop_pulse_q;

endmodule

// File: tb/tb_port_requester.sv
// Directed bench for port_requester: vector table plus hand-written sequences.
module tb_port_requester;
    import packet_pkg::*;

    localparam int unsigned Depth = 8;

    logic clk = 1'b0;
    logic rst_n;

    port_requester_if bus();

    port_requester #(
        .DEPTH   (Depth),
        .TIMEOUT (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        e;
        logic        g;
        logic        rdy;
        logic        req;
        logic [3:0]  dst;
        logic        ov;
        logic [31:0] od;
        logic        oe;
        logic        drop;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic v, input logic [31:0] d, input logic e,
                                input logic g, input logic rdy, input logic req,
                                input logic [3:0] dst, input logic ov, input logic [31:0] od,
                                input logic oe, input logic drop);
        vec_t r;
        r.v = v; r.d = d; r.e = e; r.g = g;
        r.rdy = rdy; r.req = req; r.dst = dst; r.ov = ov; r.od = od; r.oe = oe; r.drop = drop;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic e, input logic g);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.in_eop   = e;
        bus.grant    = g;
    endtask

    // Streams packets of 1..5 words with a 2-of-3 grant pattern, scoreboarding every word.
    task automatic stream_packets(input int n_pkts, input int seed);
        logic [32:0] exp_q[$];
        logic [32:0] ex;
        logic [31:0] w;
        logic [3:0]  mask;
        logic        e;
        logic        accepted;
        int          pkt, wd, len, cyc;
        pkt = 0; wd = 0; cyc = 0; w = '0; e = 1'b0;
        while ((pkt < n_pkts || exp_q.size() != 0) && cyc < 3000) begin
            bus.in_valid = (pkt < n_pkts);
            if (pkt < n_pkts) begin
                len  = 1 + ((pkt + seed) % 5);
                mask = 4'b0001 << ((pkt + seed) % 4);
                w    = (wd == 0) ? {8'(pkt + seed), 20'h0, mask} : {8'(pkt + seed), 8'h5A, 16'(wd)};
                e    = (wd == len - 1);
                bus.in_data = w;
                bus.in_eop  = e;
            end
            bus.grant = (cyc % 3) != 2;
            accepted  = bus.in_valid && bus.in_ready;
            tick();
            cyc++;
            if (accepted) begin
                exp_q.push_back({e, w});
                wd++;
                if (e) begin
                    pkt++;
                    wd = 0;
                end
            end
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fails++;
                    $display("FAIL stream unexpected word: got %0h, expected none", bus.out_data);
                end else begin
                    ex = exp_q.pop_front();
                    check("stream data", bus.out_data, ex[31:0]);
                    check("stream eop", 32'(bus.out_eop), 32'(ex[32]));
                end
            end
        end
        check("stream complete (words outstanding)", 32'(exp_q.size() + n_pkts - pkt), 32'd0);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
        check({tag, " port_req"}, 32'(bus.port_req), 32'd0);
        check({tag, " port_dst"}, 32'(bus.port_dst), 32'd0);
        check({tag, " out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, " out_data"}, bus.out_data, 32'd0);
        check({tag, " out_eop"}, 32'(bus.out_eop), 32'd0);
        check({tag, " drop_pulse"}, 32'(bus.drop_pulse), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        tick();
        check_reset_values("reset");
        rst_n = 1'b1;
        tick();

        // 3-word packet, grant tied high
        vecs.push_back(mk(1, 32'hA000_0004, 0, 1,  1, 0, 4'h0, 0, 32'h0,         0, 0));
        vecs.push_back(mk(1, 32'h0000_1111, 0, 1,  1, 1, 4'h4, 0, 32'h0,         0, 0));
        vecs.push_back(mk(1, 32'h0000_2222, 1, 1,  1, 1, 4'h4, 1, 32'hA000_0004, 0, 0));
        vecs.push_back(mk(0, 32'h0,         0, 1,  1, 1, 4'h4, 1, 32'h0000_1111, 0, 0));
        vecs.push_back(mk(0, 32'h0,         0, 1,  1, 0, 4'h0, 1, 32'h0000_2222, 1, 0));
        vecs.push_back(mk(0, 32'h0,         0, 1,  1, 0, 4'h0, 0, 32'h0,         0, 0));
        // same shape, grant toggling 1,0,1,0,1
        vecs.push_back(mk(1, 32'hB000_0004, 0, 0,  1, 0, 4'h0, 0, 32'h0,         0, 0));
        vecs.push_back(mk(1, 32'h0000_3333, 0, 0,  1, 1, 4'h4, 0, 32'h0,         0, 0));
        vecs.push_back(mk(1, 32'h0000_4444, 1, 1,  1, 1, 4'h4, 1, 32'hB000_0004, 0, 0));
        vecs.push_back(mk(0, 32'h0,         0, 0,  1, 1, 4'h4, 0, 32'h0,         0, 0));
        vecs.push_back(mk(0, 32'h0,         0, 1,  1, 1, 4'h4, 1, 32'h0000_3333, 0, 0));
        vecs.push_back(mk(0, 32'h0,         0, 0,  1, 1, 4'h4, 0, 32'h0,         0, 0));
        vecs.push_back(mk(0, 32'h0,         0, 1,  1, 0, 4'h0, 1, 32'h0000_4444, 1, 0));
        vecs.push_back(mk(0, 32'h0,         0, 0,  1, 0, 4'h0, 0, 32'h0,         0, 0));
        // zero-mask header dropped; grant held high must not pop or forward anything
        vecs.push_back(mk(1, 32'hC000_0000, 0, 1,  1, 0, 4'h0, 0, 32'h0,         0, 0));
        vecs.push_back(mk(1, 32'h0000_5555, 0, 1,  1, 0, 4'h0, 0, 32'h0,         0, 1));
        vecs.push_back(mk(1, 32'h0000_6666, 1, 1,  1, 0, 4'h0, 0, 32'h0,         0, 0));
        vecs.push_back(mk(0, 32'h0,         0, 1,  1, 0, 4'h0, 0, 32'h0,         0, 0));
        vecs.push_back(mk(0, 32'h0,         0, 1,  1, 0, 4'h0, 0, 32'h0,         0, 0));
        vecs.push_back(mk(0, 32'h0,         0, 1,  1, 0, 4'h0, 0, 32'h0,         0, 0));
        // single-word packet proves the FIFO was emptied by the drop
        vecs.push_back(mk(1, 32'hE000_0001, 1, 1,  1, 0, 4'h0, 0, 32'h0,         0, 0));
        vecs.push_back(mk(0, 32'h0,         0, 1,  1, 1, 4'h1, 0, 32'h0,         0, 0));
        vecs.push_back(mk(0, 32'h0,         0, 1,  1, 0, 4'h0, 1, 32'hE000_0001, 1, 0));
        vecs.push_back(mk(0, 32'h0,         0, 0,  1, 0, 4'h0, 0, 32'h0,         0, 0));

        foreach (vecs[i]) begin
            drive(vecs[i].v, vecs[i].d, vecs[i].e, vecs[i].g);
            tick();
            check($sformatf("vec%0d in_ready", i), 32'(bus.in_ready), 32'(vecs[i].rdy));
            check($sformatf("vec%0d port_req", i), 32'(bus.port_req), 32'(vecs[i].req));
            check($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), 32'(vecs[i].ov));
            check($sformatf("vec%0d out_eop", i), 32'(bus.out_eop), 32'(vecs[i].oe));
            check($sformatf("vec%0d drop_pulse", i), 32'(bus.drop_pulse), 32'(vecs[i].drop));
            if (vecs[i].req) begin
                check($sformatf("vec%0d port_dst", i), 32'(bus.port_dst), 32'(vecs[i].dst));
            end
            if (vecs[i].ov) begin
                check($sformatf("vec%0d out_data", i), bus.out_data, vecs[i].od);
            end
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);

`ifndef REQ_TIMEOUT_EN
        // Fill to DEPTH with no grant, then release one word at a time.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, (i == 0) ? 32'hD000_0002 : 32'h0000_0D00 + 32'(i), 1'b0, 1'b0);
            tick();
            if (i == 6) check("fill 7 in_ready", 32'(bus.in_ready), 32'd1);
        end
        check("fill 8 in_ready", 32'(bus.in_ready), 32'd0);
        check("fill 8 port_req", 32'(bus.port_req), 32'd1);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        check("fill pop out_valid", 32'(bus.out_valid), 32'd1);
        check("fill pop out_data", bus.out_data, 32'hD000_0002);
        check("fill pop in_ready", 32'(bus.in_ready), 32'd1);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        check("fill hold out_valid", 32'(bus.out_valid), 32'd0);
        drive(1'b1, 32'h0000_0D08, 1'b1, 1'b1);
        tick();
        check("drain 1 out_data", bus.out_data, 32'h0000_0D01);
        bus.in_valid = 1'b0;
        for (int i = 2; i <= 8; i++) begin
            tick();
            check($sformatf("drain %0d out_valid", i), 32'(bus.out_valid), 32'd1);
            check($sformatf("drain %0d out_data", i), bus.out_data, 32'h0000_0D00 + 32'(i));
            check($sformatf("drain %0d out_eop", i), 32'(bus.out_eop), 32'(i == 8));
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        check("drain done port_req", 32'(bus.port_req), 32'd0);
        check("drain done out_valid", 32'(bus.out_valid), 32'd0);
`endif

        // 20 packets, 60 words total: pointers wrap several times.
        stream_packets(20, 0);

        // Reset after 2 of 5 words forwarded.
        bus.grant = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, (i == 0) ? 32'hF000_0001 : 32'h0000_0F00 + 32'(i), 1'b0, 1'b1);
            tick();
        end
        check("pre-reset out_valid", 32'(bus.out_valid), 32'd1);
        check("pre-reset out_data", bus.out_data, 32'h0000_0F01);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check_reset_values("mid-packet reset");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check_reset_values("post-reset idle");
        stream_packets(2, 7);

`ifdef REQ_TIMEOUT_EN
        drive(1'b1, 32'h1000_0002, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h0000_1001, 1'b1, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        check("timeout req rises", 32'(bus.port_req), 32'd1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("timeout wait %0d port_req", i), 32'(bus.port_req), 32'd1);
            check($sformatf("timeout wait %0d drop", i), 32'(bus.drop_pulse), 32'd0);
        end
        tick();
        check("timeout drop_pulse", 32'(bus.drop_pulse), 32'd1);
        check("timeout port_req", 32'(bus.port_req), 32'd0);
        tick();
        check("timeout drop_pulse single", 32'(bus.drop_pulse), 32'd0);
        check("timeout out_valid", 32'(bus.out_valid), 32'd0);
        stream_packets(1, 3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
